// File: rtl/spiker_sequencer.sv
// ---------------------------------------------------------------------------
// spiker_sequencer
//
// Sequences one inference on the spiker core. A start command streams the
// packed input-spike words from the adapter register file into the core over
// a valid/ready channel. The block then waits for the core's result beats,
// writes them back to the result registers, and reports done/error/irq
// status. A RUN-phase timer guards against a core that never answers. An
// abort command returns to IDLE from any state.
//
// Ports:
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   start_i        one-cycle start command (honoured only in IDLE)
//   abort_i        one-cycle abort command (ignored in IDLE)
//   spk_rd_addr_o  word index into the spike registers
//   spk_rd_data_i  spike word at spk_rd_addr_o, valid in the same cycle
//   core_data_o    spike word to the core, bits >= N_SPIKES masked to 0
//   core_valid_o   core_data_o is valid (LOAD state)
//   core_ready_i   core accepts the current word
//   core_last_o    marks word N_WORDS-1
//   res_valid_i    result beat from the core (no backpressure)
//   res_data_i     result data
//   res_wr_en_o    result register write strobe
//   res_wr_addr_o  result register index
//   res_wr_data_o  result register data
//   busy_o         high while not IDLE
//   done_o         sticky: last inference completed
//   error_o        sticky: last inference timed out
//   irq_o          one-cycle pulse on completion or timeout
// ---------------------------------------------------------------------------
module spiker_sequencer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned N_SPIKES       = 784,
  parameter int unsigned N_OUT_WORDS    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned N_WORDS = (N_SPIKES + WIDTH - 1) / WIDTH,
  localparam int unsigned AW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
  localparam int unsigned RW      = (N_OUT_WORDS > 1) ? $clog2(N_OUT_WORDS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [AW-1:0]    spk_rd_addr_o,
  input  logic [WIDTH-1:0] spk_rd_data_i,
  output logic [WIDTH-1:0] core_data_o,
  output logic             core_valid_o,
  input  logic             core_ready_i,
  output logic             core_last_o,
  input  logic             res_valid_i,
  input  logic [WIDTH-1:0] res_data_i,
  output logic             res_wr_en_o,
  output logic [RW-1:0]    res_wr_addr_o,
  output logic [WIDTH-1:0] res_wr_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic             irq_o
);

  localparam int unsigned TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned REM = N_SPIKES % WIDTH;

  localparam logic [AW-1:0] LAST_WORD = AW'(N_WORDS - 1);
  localparam logic [RW-1:0] LAST_RES  = RW'(N_OUT_WORDS - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  // Keeps only the bits of the final word that carry real spikes. When the
  // spike count is a whole number of words, nothing is masked.
  localparam logic [WIDTH-1:0] LAST_MASK =
    (REM == 0) ? {WIDTH{1'b1}} : ({WIDTH{1'b1}} >> (WIDTH - REM));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   word_q, word_d;
  logic [RW-1:0]   res_q, res_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            irq_q, irq_d;

  logic            is_last_word;
  logic            is_last_res;

  assign is_last_word = (word_q == LAST_WORD);
  assign is_last_res  = (res_q == LAST_RES);

  // State and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      word_q  <= '0;
      res_q   <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      res_q   <= res_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      error_q <= error_d;
      irq_q   <= irq_d;
    end
  end

  // Next-state logic. Abort outranks everything outside IDLE, including a
  // final handshake or final beat in the same cycle. done/irq are set on the
  // edge into FINISH, so both are already visible during the FINISH cycle.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    res_d   = res_q;
    timer_d = timer_q;
    done_d  = done_q;
    error_d = error_q;
    irq_d   = 1'b0;

    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      word_d  = '0;
      res_d   = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            state_d = LOAD;
            word_d  = '0;
            res_d   = '0;
            timer_d = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
          end
        end

        LOAD: begin
          if (core_ready_i) begin
            if (is_last_word) begin
              word_d  = '0;
              state_d = RUN;
            end else begin
              word_d = word_q + 1'b1;
            end
          end
        end

        RUN: begin
          timer_d = timer_q + 1'b1;
          // The final beat wins over a coincident timeout.
          if (res_valid_i && is_last_res) begin
            res_d   = '0;
            timer_d = '0;
            done_d  = 1'b1;
            irq_d   = 1'b1;
            state_d = FINISH;
          end else begin
            if (res_valid_i) begin
              res_d = res_q + 1'b1;
            end
            if (timer_q == TIMER_MAX) begin
              res_d   = '0;
              timer_d = '0;
              error_d = 1'b1;
              irq_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end

        FINISH: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Spike channel. The address comes straight from the word counter, so it
  // (and the data read through it) holds while the core stalls.
  assign spk_rd_addr_o = word_q;
  assign core_valid_o  = (state_q == LOAD);
  assign core_last_o   = (state_q == LOAD) && is_last_word;
  assign core_data_o   = is_last_word ? (spk_rd_data_i & LAST_MASK) : spk_rd_data_i;

  // Result write-back is a combinational pass-through of the beat. It still
  // fires in a cycle where abort is also asserted.
  assign res_wr_en_o   = (state_q == RUN) && res_valid_i;
  assign res_wr_addr_o = res_q;
  assign res_wr_data_o = res_data_i;

  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign error_o = error_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_spiker_sequencer.sv
// ---------------------------------------------------------------------------
// tb_spiker_sequencer
//
// Directed bench for spiker_sequencer with default geometry (25 words,
// 784 spikes, 1 result beat) and a 16-cycle timeout. The spike register file
// is a combinational function of the read address. In ones-mode every word
// reads as all ones.
// ---------------------------------------------------------------------------
module tb_spiker_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        abort_i;
  logic [4:0]  spk_rd_addr_o;
  logic [31:0] spk_rd_data_i;
  logic [31:0] core_data_o;
  logic        core_valid_o;
  logic        core_ready_i;
  logic        core_last_o;
  logic        res_valid_i;
  logic [31:0] res_data_i;
  logic        res_wr_en_o;
  logic [0:0]  res_wr_addr_o;
  logic [31:0] res_wr_data_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        irq_o;

  logic        allOnes;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk_i = ~clk_i;

  assign spk_rd_data_i = allOnes ? 32'hFFFF_FFFF
                                 : (32'h5A5A_0000 | (32'(spk_rd_addr_o) * 32'h0101));

  spiker_sequencer #(
    .WIDTH(32),
    .N_SPIKES(784),
    .N_OUT_WORDS(1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .abort_i(abort_i),
    .spk_rd_addr_o(spk_rd_addr_o),
    .spk_rd_data_i(spk_rd_data_i),
    .core_data_o(core_data_o),
    .core_valid_o(core_valid_o),
    .core_ready_i(core_ready_i),
    .core_last_o(core_last_o),
    .res_valid_i(res_valid_i),
    .res_data_i(res_data_i),
    .res_wr_en_o(res_wr_en_o),
    .res_wr_addr_o(res_wr_addr_o),
    .res_wr_data_o(res_wr_data_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .error_o(error_o),
    .irq_o(irq_o)
  );

  // Expected word on the core channel. 784 mod 32 = 16, so only the low
  // 16 bits of word 24 survive.
  function automatic logic [31:0] expWord(input int a, input logic ones);
    logic [31:0] w;
    w = ones ? 32'hFFFF_FFFF : (32'h5A5A_0000 | (32'(a) * 32'h0101));
    if (a == 24) w = w & 32'h0000_FFFF;
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic rdy,
                               input logic rv, input logic [31:0] rd);
    start_i      = st;
    abort_i      = ab;
    core_ready_i = rdy;
    res_valid_i  = rv;
    res_data_i   = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int hs;
    int cyc;
    logic rdy;

    allOnes = 1'b0;
    rst_i   = 1'b1;
    applyStimulus(0, 0, 0, 0, 32'h0);
    tick();
    tick();

    $display("[TB] reset values");
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_error", error_o, 0);
    checkOutput("rst_irq", irq_o, 0);
    checkOutput("rst_valid", core_valid_o, 0);
    checkOutput("rst_last", core_last_o, 0);
    checkOutput("rst_wr_en", res_wr_en_o, 0);
    checkOutput("rst_rd_addr", spk_rd_addr_o, 0);
    checkOutput("rst_wr_addr", res_wr_addr_o, 0);
    rst_i = 1'b0;
    tick();

    applyStimulus(0, 0, 1, 1, 32'h1234_5678);
    checkOutput("idle_res_ignored", res_wr_en_o, 0);

    $display("[TB] nominal run");
    applyStimulus(1, 0, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("nom_busy", busy_o, 1);
    for (int k = 0; k < 25; k++) begin
      checkOutput("nom_valid", core_valid_o, 1);
      checkOutput("nom_addr", spk_rd_addr_o, k);
      checkOutput("nom_data", core_data_o, expWord(k, 1'b0));
      checkOutput("nom_last", core_last_o, (k == 24) ? 1 : 0);
      tick();
    end
    checkOutput("nom_run_valid", core_valid_o, 0);
    checkOutput("nom_run_busy", busy_o, 1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("nom_run_irq", irq_o, 0);
      tick();
    end
    applyStimulus(0, 0, 1, 1, 32'hCAFE_F00D);
    checkOutput("nom_wr_en", res_wr_en_o, 1);
    checkOutput("nom_wr_addr", res_wr_addr_o, 0);
    checkOutput("nom_wr_data", res_wr_data_o, 32'hCAFE_F00D);
    tick();
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("nom_fin_irq", irq_o, 1);
    checkOutput("nom_fin_done", done_o, 1);
    checkOutput("nom_fin_busy", busy_o, 1);
    checkOutput("nom_fin_wr_en", res_wr_en_o, 0);
    tick();
    checkOutput("nom_idle_irq", irq_o, 0);
    checkOutput("nom_idle_busy", busy_o, 0);
    checkOutput("nom_idle_done", done_o, 1);

    $display("[TB] backpressure with all-ones spike words");
    allOnes = 1'b1;
    applyStimulus(1, 0, 0, 0, 32'h0);
    tick();
    hs  = 0;
    cyc = 0;
    while (cyc < 200) begin
      rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      applyStimulus(0, 0, rdy, 0, 32'h0);
      if (!core_valid_o) break;
      checkOutput("bp_addr", spk_rd_addr_o, hs);
      checkOutput("bp_data", core_data_o, expWord(hs, 1'b1));
      checkOutput("bp_last", core_last_o, (hs == 24) ? 1 : 0);
      if (rdy) hs++;
      cyc++;
      tick();
    end
    checkOutput("bp_handshakes", hs, 25);
    checkOutput("bp_run_valid", core_valid_o, 0);
    checkOutput("bp_run_busy", busy_o, 1);
    applyStimulus(0, 0, 1, 1, 32'h0BAD_BEEF);
    checkOutput("bp_wr_en", res_wr_en_o, 1);
    tick();
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("bp_irq", irq_o, 1);
    tick();
    allOnes = 1'b0;

    $display("[TB] timeout");
    applyStimulus(1, 0, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("to_done_cleared", done_o, 0);
    for (int k = 0; k < 25; k++) begin
      checkOutput("to_load_addr", spk_rd_addr_o, k);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      checkOutput("to_run_busy", busy_o, 1);
      checkOutput("to_run_irq", irq_o, 0);
      tick();
    end
    checkOutput("to_busy", busy_o, 0);
    checkOutput("to_error", error_o, 1);
    checkOutput("to_irq", irq_o, 1);
    checkOutput("to_done", done_o, 0);
    tick();
    checkOutput("to_irq_single", irq_o, 0);
    checkOutput("to_error_sticky", error_o, 1);

    $display("[TB] start with abort in IDLE");
    applyStimulus(1, 1, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("idle_abort_busy", busy_o, 0);
    checkOutput("idle_abort_error", error_o, 1);

    $display("[TB] abort in LOAD at word 7");
    applyStimulus(1, 0, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("ab_error_cleared", error_o, 0);
    for (int k = 0; k < 7; k++) tick();
    checkOutput("ab_addr7", spk_rd_addr_o, 7);
    applyStimulus(0, 1, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("ab_busy", busy_o, 0);
    checkOutput("ab_irq", irq_o, 0);
    checkOutput("ab_valid", core_valid_o, 0);
    checkOutput("ab_done", done_o, 0);
    tick();
    checkOutput("ab_irq_after", irq_o, 0);

    $display("[TB] restart, then start during RUN");
    applyStimulus(1, 0, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("rs_valid", core_valid_o, 1);
    for (int k = 0; k < 25; k++) begin
      checkOutput("rs_addr", spk_rd_addr_o, k);
      tick();
    end
    tick();
    tick();
    tick();
    applyStimulus(1, 0, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("rs_run_busy", busy_o, 1);
    checkOutput("rs_run_valid", core_valid_o, 0);
    for (int i = 0; i < 11; i++) tick();
    checkOutput("rs_busy_s15", busy_o, 1);
    tick();
    checkOutput("rs_to_busy", busy_o, 0);
    checkOutput("rs_to_error", error_o, 1);
    checkOutput("rs_to_irq", irq_o, 1);
    tick();

    $display("[TB] reset during LOAD");
    applyStimulus(1, 0, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 0, 32'h0);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("rl_addr5", spk_rd_addr_o, 5);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("rl_busy", busy_o, 0);
    checkOutput("rl_done", done_o, 0);
    checkOutput("rl_error", error_o, 0);
    checkOutput("rl_irq", irq_o, 0);
    checkOutput("rl_valid", core_valid_o, 0);
    checkOutput("rl_last", core_last_o, 0);
    checkOutput("rl_wr_en", res_wr_en_o, 0);
    checkOutput("rl_rd_addr", spk_rd_addr_o, 0);
    checkOutput("rl_wr_addr", res_wr_addr_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
